// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register file and its checkpoint store.
// Latency: n/a (package only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int NREG_DEF   = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 4;
  localparam int NRD_DEF    = 4;
  localparam int NDP_DEF    = 2;
  localparam int NCM_DEF    = 2;
  localparam int NCKPT_DEF  = 4;

  localparam int REG_W  = $clog2(NREG_DEF);
  localparam int CKPT_W = $clog2(NCKPT_DEF);

  // All-zero tag: the architectural value lives in the register file.
  localparam logic [TAG_W_DEF-1:0] TAG_FREE = '0;

  // Whole rename map, one tag per architectural register.
  typedef logic [NREG_DEF-1:0][TAG_W_DEF-1:0] tag_map_t;

endpackage

// File: rtl/regfile_ckpt_store.sv
// regfile_ckpt_store: circular FIFO of tag-map snapshots for branch recovery.
// Latency: take/restore/release update state at the edge; restore_map is combinational.
// Backpressure: take while full is dropped and flagged by a one-cycle ckpt_ovf pulse.
// Ports: take_req/restore_req/restore_id/rel_req control the FIFO; commit_* clear
// matching tags in every slot; live_map is the next-cycle live tag map to snapshot;
// restore_map is the selected slot with this cycle's commits applied.
module regfile_ckpt_store
  import regfile_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NCM   = NCM_DEF,
  parameter int NCKPT = NCKPT_DEF,
  localparam int RW   = $clog2(NREG),
  localparam int CW   = $clog2(NCKPT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic                          clear,
  input  logic                          take_req,
  input  logic                          restore_req,
  input  logic [CW-1:0]                 restore_id,
  input  logic                          rel_req,
  input  logic [NCM-1:0]                commit_en,
  input  logic [NCM-1:0][RW-1:0]        commit_reg,
  input  logic [NCM-1:0][TAG_W-1:0]     commit_tag,
  input  logic [NREG-1:0][TAG_W-1:0]    live_map,
  output logic [NREG-1:0][TAG_W-1:0]    restore_map,
  output logic [CW-1:0]                 ckpt_id,
  output logic                          ckpt_full,
  output logic                          ckpt_ovf
);

  localparam int CNT_W = CW + 1;
  localparam logic [TAG_W-1:0] TFREE = TAG_W'(TAG_FREE);

  logic [NREG-1:0][TAG_W-1:0] slot_q   [NCKPT];
  logic [NREG-1:0][TAG_W-1:0] slot_d   [NCKPT];
  logic [NREG-1:0][TAG_W-1:0] slot_clr [NCKPT];
  logic [CW-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic                       take_ok, rel_ok;

  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    return (p == CW'(NCKPT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every slot drops tags retired this cycle. Invalid slots are cleared too;
  // harmless, since a slot is fully overwritten when it is next taken.
  always_comb begin
    for (int s = 0; s < NCKPT; s++) begin
      slot_clr[s] = slot_q[s];
      for (int c = 0; c < NCM; c++) begin
        if (commit_en[c] && commit_reg[c] != '0 &&
            slot_q[s][commit_reg[c]] == commit_tag[c]) begin
          slot_clr[s][commit_reg[c]] = TFREE;
        end
      end
    end
  end

  assign restore_map = slot_clr[restore_id];
  assign ckpt_id     = tail_q;
  assign ckpt_full   = (count_q == CNT_W'(NCKPT));
  assign ckpt_ovf    = ovf_q;

  always_comb begin
    slot_d  = slot_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    take_ok = 1'b0;
    rel_ok  = 1'b0;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (rdy) begin
      slot_d = slot_clr;
      ovf_d  = 1'b0;
      if (restore_req) begin
        // Free the restored slot and everything younger: count = (k - head) mod NCKPT.
        tail_d = restore_id;
        if (restore_id >= head_q) begin
          count_d = {1'b0, restore_id - head_q};
        end else begin
          count_d = CNT_W'(NCKPT) - {1'b0, head_q} + {1'b0, restore_id};
        end
      end else begin
        take_ok = take_req && !ckpt_full;
        ovf_d   = take_req && ckpt_full;
        rel_ok  = rel_req && (count_q != '0);
        if (take_ok) begin
          slot_d[tail_q] = live_map;
          tail_d         = ptr_inc(tail_q);
        end
        if (rel_ok) begin
          head_d = ptr_inc(head_q);
        end
        case ({take_ok, rel_ok})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '{default: {NREG{TFREE}}};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/regfile_ckpt.sv
// regfile_ckpt: architectural register file + rename-tag map with branch checkpoints.
// Latency: reads combinational (commit bypass same cycle); updates visible next cycle.
// Backpressure: none; stall squashes dispatch/ckpt_take, rdy low freezes all state.
// Ports: commit_* (NCM ROB write ports), dp_* (NDP rename ports, higher index younger),
// rd_sel/rd_tag/rd_data (NRD read ports), ckpt_* (checkpoint take/restore/release/status),
// clear (flush all tags, keep data), rdy (global enable), clk/rst_n.
module regfile_ckpt
  import regfile_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NDP    = NDP_DEF,
  parameter int NCM    = NCM_DEF,
  parameter int NCKPT  = NCKPT_DEF,
  localparam int RW    = $clog2(NREG),
  localparam int CW    = $clog2(NCKPT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic                          clear,
  input  logic                          stall,
  input  logic [NCM-1:0]                commit_en,
  input  logic [NCM-1:0][RW-1:0]        commit_reg,
  input  logic [NCM-1:0][DATA_W-1:0]    commit_data,
  input  logic [NCM-1:0][TAG_W-1:0]     commit_tag,
  input  logic [NDP-1:0]                dp_en,
  input  logic [NDP-1:0][RW-1:0]        dp_reg,
  input  logic [NDP-1:0][TAG_W-1:0]     dp_tag,
  input  logic [NRD-1:0][RW-1:0]        rd_sel,
  output logic [NRD-1:0][TAG_W-1:0]     rd_tag,
  output logic [NRD-1:0][DATA_W-1:0]    rd_data,
  input  logic                          ckpt_take,
  output logic [CW-1:0]                 ckpt_id,
  output logic                          ckpt_full,
  output logic                          ckpt_ovf,
  input  logic                          ckpt_restore,
  input  logic [CW-1:0]                 ckpt_restore_id,
  input  logic                          ckpt_release
);

  localparam logic [TAG_W-1:0] TFREE = TAG_W'(TAG_FREE);

  logic [DATA_W-1:0]          data_q [NREG];
  logic [DATA_W-1:0]          data_d [NREG];
  logic [NREG-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [NREG-1:0][TAG_W-1:0] restore_map;

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (clear) begin
      tag_d = {NREG{TFREE}};
    end else if (rdy) begin
      // Ascending port order: the younger commit's data wins on a same-reg clash.
      for (int c = 0; c < NCM; c++) begin
        if (commit_en[c] && commit_reg[c] != '0) begin
          data_d[commit_reg[c]] = commit_data[c];
        end
      end
      if (ckpt_restore) begin
        tag_d = restore_map;
      end else begin
        for (int c = 0; c < NCM; c++) begin
          if (commit_en[c] && commit_reg[c] != '0 && tag_q[commit_reg[c]] == commit_tag[c]) begin
            tag_d[commit_reg[c]] = TFREE;
          end
        end
        // Renames land after the frees, so a same-cycle dispatch to the
        // committing reg keeps its new tag instead of being freed.
        if (!stall) begin
          for (int d = 0; d < NDP; d++) begin
            if (dp_en[d] && dp_reg[d] != '0) begin
              tag_d[dp_reg[d]] = dp_tag[d];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '{default: '0};
      tag_q  <= {NREG{TFREE}};
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  // Reads: reg 0 is zero; a commit retiring the reg's current tag bypasses.
  // Gated by rst_n so outputs sit at 0/free while reset is held.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_data[r] = '0;
      rd_tag[r]  = TFREE;
      if (rst_n && rd_sel[r] != '0) begin
        rd_data[r] = data_q[rd_sel[r]];
        rd_tag[r]  = tag_q[rd_sel[r]];
        for (int c = 0; c < NCM; c++) begin
          if (commit_en[c] && commit_reg[c] == rd_sel[r] &&
              commit_tag[c] == tag_q[rd_sel[r]]) begin
            rd_data[r] = commit_data[c];
            rd_tag[r]  = TFREE;
          end
        end
      end
    end
  end

  regfile_ckpt_store #(
    .NREG  (NREG),
    .TAG_W (TAG_W),
    .NCM   (NCM),
    .NCKPT (NCKPT)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .clear       (clear),
    .take_req    (ckpt_take && !stall),
    .restore_req (ckpt_restore),
    .restore_id  (ckpt_restore_id),
    .rel_req     (ckpt_release),
    .commit_en   (commit_en),
    .commit_reg  (commit_reg),
    .commit_tag  (commit_tag),
    .live_map    (tag_d),
    .restore_map (restore_map),
    .ckpt_id     (ckpt_id),
    .ckpt_full   (ckpt_full),
    .ckpt_ovf    (ckpt_ovf)
  );

endmodule
